multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Multicycle sequencer for the MIPS datapath. Replaces per-instruction combinational decode with a Moore/Mealy FSM.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath muxes, register-file and memory enables, and ALU op selection.
- Shares one memory port between instruction fetch and data access using a ready handshake with a timeout.

Parameters:
- MEM_TIMEOUT, 255, max cycles to wait for mem_ready in any memory state before entering ERROR (1..65535).
- CNT_W, 16, width of the timeout counter; must satisfy 2**CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; leaving IDLE and continuing past each retire require run=1.
- opcode  in  6  instruction opcode from IR; only opcode[2:0] decoded.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current access in this cycle.
- mem_read  out  1  memory read request (FETCH, MEMRD).
- mem_write  out  1  memory write request (MEMWR).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_src  out  1  PC input select: 0=ALU result (PC+4), 1=ALUOut (branch target).
- reg_dst  out  1  write-register select: 1=rd, 0=rt.
- mem_to_reg  out  1  write-data select: 1=MDR, 0=ALUOut.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  2  ALU op: 00=add, 01=sub, 10=funct decode, 11=and.
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for opcode[2:0] = 010 or 011.
- mem_error  out  1  high while in ERROR.

Behaviour:
- Opcode decode, opcode[2:0]: 000 RTYPE, 001 ADDI, 100 LW, 101 SW, 110 BEQ, 111 ANDI; 010 and 011 are illegal.
- Reset: state=IDLE, timeout counter=0, every output 0. Reset asserted mid-instruction aborts immediately with no further writes.
- Unless stated, outputs depend on state only. Exception: ir_write, pc_write and state exit in memory states also require mem_ready.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - RTYPE goes to EXEC.
  - LW and SW go to MEMADR.
  - BEQ goes to BRANCH.
  - ADDI and ANDI go to IMMEX.
  - Illegal: illegal_op=1, instr_retired=1, then FETCH if run=1, else IDLE.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_retired=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW goes to MEMRD, SW goes to MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Go to MEMWB on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_retired=1.
- MEMWR: mem_write=1, i_or_d=1. On mem_ready: instr_retired=1 and take the retire exit.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero, instr_retired=1.
- IMMEX: alu_src_a=1, alu_src_b=10. alu_op=00 for ADDI, 11 for ANDI. Go to IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_retired=1.
- Retire exit (every state that pulses instr_retired): go to FETCH if run=1, else IDLE.
- Latency at zero memory wait: BEQ 3, RTYPE/ADDI/ANDI/SW 4, LW 5 cycles. Each wait cycle adds 1.
- Timeout counter:
  - Clears on entry to any memory state (FETCH, MEMRD, MEMWR).
  - Increments each cycle there with mem_ready=0.
  - Reaching MEM_TIMEOUT goes to ERROR.
  - mem_ready=1 on the cycle the count reaches MEM_TIMEOUT: completion wins.
- ERROR: mem_error=1, all other outputs 0. Left only by rst.
- run is sampled only in IDLE and at retire exits. Deasserting run mid-instruction does not abort; the instruction completes.
- opcode is sampled only in DECODE, MEMADR and IMMEX. The IR is stable after FETCH.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, IMMEX, IMMWB, ERROR);
  - opcode[2:0] localparams;
  - alu_op and alu_src_b encodings.
- One sub-module, mem_wait_timer: counter with clear, enable and expired outputs, parameterised by MEM_TIMEOUT and CNT_W.

Test Plan:
- Reset then run=1, opcode=000, mem_ready tied 1 -> states FETCH, DECODE, EXEC, ALUWB. ir_write and pc_write high in cycle 1; reg_write=1 and reg_dst=1 in cycle 4; instr_retired pulses every 4 cycles.
- opcode=100, mem_ready low 2 cycles in FETCH and 3 in MEMRD -> retire after 10 cycles. mem_read held high throughout the waits; ir_write only on the ready cycle; mem_to_reg=1 in MEMWB.
- opcode=110 with zero=1, then repeat with zero=0 -> pc_write=1 then 0 in BRANCH, pc_src=1, alu_op=01; 3-cycle retire both times.
- opcode=011 -> illegal_op pulse in DECODE, no reg_write/mem_write/pc_write beyond fetch, next state FETCH.
- MEM_TIMEOUT=4, mem_ready=0 in MEMWR -> ERROR after 4 wait cycles, mem_error=1 and stays 1 until rst. Second run: mem_ready=1 on the 4th cycle -> normal retire.
- rst asserted asynchronously mid-MEMRD -> all outputs 0 immediately, state IDLE. Also: run=0 during an instruction -> it completes, then IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer:
// state encoding, decoded opcode values and datapath select encodings.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_ALUWB,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_BRANCH,
        ST_IMMEX,
        ST_IMMWB,
        ST_ERROR
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_ANDI  = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that own the shared memory port and wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired_o flags that the current wait cycle
// is the last one allowed before the sequencer must give up.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_ctrl_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       i_or_d_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       instr_retired_o,
    output logic       illegal_op_o,
    output logic       mem_error_o
);

    state_t     state_q;
    state_t     state_d;
    state_t     retire_next;
    logic [2:0] op;
    logic       timer_expired;
    logic       unused_opcode_hi;

    assign op               = opcode_i[2:0];
    assign unused_opcode_hi = ^opcode_i[5:3];
    assign retire_next      = run_i ? ST_FETCH : ST_IDLE;

    // Counter restarts whenever the state changes, so every memory state entry starts at zero.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_d != state_q),
        .en_i     (is_mem_state(state_q) && !mem_ready_i),
        .expired_o(timer_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        i_or_d_o        = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_src_o        = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALU_ADD;
        instr_retired_o = 1'b0;
        illegal_op_o    = 1'b0;
        mem_error_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH2;
                case (op)
                    OP_RTYPE:       state_d = ST_EXEC;
                    OP_LW, OP_SW:   state_d = ST_MEMADR;
                    OP_BEQ:         state_d = ST_BRANCH;
                    OP_ADDI, OP_ANDI: state_d = ST_IMMEX;
                    default: begin
                        illegal_op_o    = 1'b1;
                        instr_retired_o = 1'b1;
                        state_d         = retire_next;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
                state_d     = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write_o     = 1'b1;
                reg_dst_o       = 1'b1;
                instr_retired_o = 1'b1;
                state_d         = retire_next;
            end
            ST_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                state_d     = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i) state_d = ST_MEMWB;
                else if (timer_expired) state_d = ST_ERROR;
            end
            ST_MEMWB: begin
                reg_write_o     = 1'b1;
                mem_to_reg_o    = 1'b1;
                instr_retired_o = 1'b1;
                state_d         = retire_next;
            end
            ST_MEMWR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) begin
                    instr_retired_o = 1'b1;
                    state_d         = retire_next;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_src_o        = 1'b1;
                pc_write_o      = zero_i;
                instr_retired_o = 1'b1;
                state_d         = retire_next;
            end
            ST_IMMEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = (op == OP_ANDI) ? ALU_AND : ALU_ADD;
                state_d     = ST_IMMWB;
            end
            ST_IMMWB: begin
                reg_write_o     = 1'b1;
                instr_retired_o = 1'b1;
                state_d         = retire_next;
            end
            ST_ERROR: begin
                mem_error_o = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
